// File: rtl/fetch.sv
// Instruction fetch stage: PC generation, credit-limited memory requests, ibuf queue to decode.
// Optional FETCH_PERF_CNT_EN macro enables the perf_ibuf_empty_cnt counter.
module fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  output logic        valid_de0,
  output logic [31:0] instr_de0,
  output logic [31:0] pc_de0,
  input  logic        stall_de0,
  output logic [31:0] perf_ibuf_empty_cnt
);

  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [3:0]    outstanding_reg;
  logic [3:0]    drop_cnt_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   instr_reg;
  logic [31:0]   pc_reg;

  logic [31:0]   ibuf_instr [IBUF_DEPTH];
  logic [31:0]   ibuf_pc    [IBUF_DEPTH];

  logic          credit_ok;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [31:0]   target_pc;
  logic [CW-1:0] count_after_pop;
  logic [AW-1:0] head_idx;
  logic [31:0]   head_instr_next;
  logic [31:0]   head_pc_next;
  logic          head_load;
  logic          unused_target_bits;

  assign target_pc          = {br_target[31:2], 2'b00};
  assign unused_target_bits = ^br_target[1:0];

  // Credit: every in-flight request already owns an ibuf slot, so responses never back up.
  assign credit_ok = (int'(outstanding_reg) < MAX_OUTSTANDING) &&
                     (int'(outstanding_reg) + int'(count_reg) < IBUF_DEPTH);

  assign mem_req_valid = !reset && !br_redirect && credit_ok;
  assign mem_req_addr  = fetch_pc_reg;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign push = mem_rsp_valid && !br_redirect && (drop_cnt_reg == 4'd0);
  assign pop  = (count_reg != '0) && !stall_de0 && !br_redirect;

  assign count_after_pop = count_reg - CW'(pop);
  assign head_idx        = rd_ptr_reg + AW'(pop);

  // The head register tracks the oldest surviving entry; a push into an emptied queue bypasses storage.
  always_comb begin
    head_instr_next = ibuf_instr[head_idx];
    head_pc_next    = ibuf_pc[head_idx];
    head_load       = 1'b0;
    if (!br_redirect) begin
      if (count_after_pop != '0) begin
        head_load = 1'b1;
      end else if (push) begin
        head_load       = 1'b1;
        head_instr_next = mem_rsp_data;
        head_pc_next    = rsp_pc_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ibuf_instr[wr_ptr_reg] <= mem_rsp_data;
      ibuf_pc[wr_ptr_reg]    <= rsp_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= 4'd0;
      drop_cnt_reg    <= 4'd0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      instr_reg       <= 32'd0;
      pc_reg          <= 32'd0;
    end else if (br_redirect) begin
      // Everything still in flight is stale; this cycle's response is discarded outright.
      fetch_pc_reg    <= target_pc;
      rsp_pc_reg      <= target_pc;
      outstanding_reg <= outstanding_reg - 4'(mem_rsp_valid);
      drop_cnt_reg    <= outstanding_reg - 4'(mem_rsp_valid);
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      outstanding_reg <= outstanding_reg + 4'(req_fire) - 4'(mem_rsp_valid);
      if (mem_rsp_valid && (drop_cnt_reg != 4'd0)) begin
        drop_cnt_reg <= drop_cnt_reg - 4'd1;
      end
      if (push) begin
        rsp_pc_reg <= rsp_pc_reg + 32'd4;
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= head_idx;
      count_reg  <= count_after_pop + CW'(push);
      if (head_load) begin
        instr_reg <= head_instr_next;
        pc_reg    <= head_pc_next;
      end
    end
  end

  assign valid_de0 = (count_reg != '0);
  assign instr_de0 = instr_reg;
  assign pc_de0    = pc_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt_reg <= 32'd0;
    end else if (!valid_de0 && (perf_cnt_reg != 32'hFFFF_FFFF)) begin
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
    end
  end

  assign perf_ibuf_empty_cnt = perf_cnt_reg;
`else
  assign perf_ibuf_empty_cnt = 32'd0;
`endif

  // A response with nothing in flight, or a push into a full queue without a pop, means the credit scheme broke.
  assert property (@(posedge clk) disable iff (reset) !(mem_rsp_valid && (outstanding_reg == 4'd0)));
  assert property (@(posedge clk) disable iff (reset)
                   !(push && !pop && (int'(count_reg) == IBUF_DEPTH)));

endmodule

// File: tb/tb_fetch.sv
// Randomized self-checking bench for fetch: in-order memory model plus a queue-level reference of the ibuf.
// Checks perf_ibuf_empty_cnt against a model when FETCH_PERF_CNT_EN is defined, else expects 0.
module tb_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'd0;
  logic        br_redirect = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        valid_de0;
  logic [31:0] instr_de0;
  logic [31:0] pc_de0;
  logic        stall_de0 = 1'b0;
  logic [31:0] perf_ibuf_empty_cnt;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RESET_PC), .IBUF_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .br_redirect(br_redirect), .br_target(br_target),
    .valid_de0(valid_de0), .instr_de0(instr_de0), .pc_de0(pc_de0), .stall_de0(stall_de0),
    .perf_ibuf_empty_cnt(perf_ibuf_empty_cnt)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Stimulus knobs applied each cycle
  bit          k_reset = 1'b1, k_ready = 1'b0, k_stall = 1'b0, k_redir = 1'b0, k_rsp_force = 1'b0;
  logic [31:0] k_target = 32'd0;
  int          k_rsp_mode = 0;   // 0: only when forced, 1: always, 2: random

  // Reference model
  logic [31:0] memq[$];          // accepted addresses awaiting a response
  ent_t        ibq[$];           // instructions decode should see, oldest first
  int          drop_m = 0;
  logic [31:0] exp_req_pc = RESET_PC;
  logic [31:0] perf_m = 32'd0;

  // Samples and expectations for the cycle just ticked
  logic        s_req_valid, s_valid, e_req_valid, e_valid;
  logic [31:0] s_req_addr, s_instr, s_pc, s_perf, e_req_addr, e_instr, e_pc, e_perf;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic tick();
    bit          go;
    logic [31:0] a;
    ent_t        e;
    @(posedge clk);
    #1;
    reset         = k_reset;
    mem_req_ready = k_ready;
    stall_de0     = k_stall;
    br_redirect   = k_redir;
    br_target     = k_target;
    go = 1'b0;
    if (!k_reset && memq.size() > 0) begin
      case (k_rsp_mode)
        0:       go = k_rsp_force;
        1:       go = 1'b1;
        default: go = ($urandom_range(1, 0) == 1);
      endcase
    end
    mem_rsp_valid = go;
    mem_rsp_data  = go ? memdata(memq[0]) : $urandom();
    @(negedge clk);
    s_req_valid = mem_req_valid;
    s_req_addr  = mem_req_addr;
    s_valid     = valid_de0;
    s_instr     = instr_de0;
    s_pc        = pc_de0;
    s_perf      = perf_ibuf_empty_cnt;
    e_valid     = (ibq.size() > 0);
    e_pc        = e_valid ? ibq[0].pc : 32'd0;
    e_instr     = e_valid ? ibq[0].instr : 32'd0;
    e_req_valid = !k_reset && !k_redir && (memq.size() < MAXO) && (memq.size() + ibq.size() < DEPTH);
    e_req_addr  = exp_req_pc;
`ifdef FETCH_PERF_CNT_EN
    e_perf      = perf_m;
`else
    e_perf      = 32'd0;
`endif
    if (k_reset) begin
      memq.delete();
      ibq.delete();
      drop_m     = 0;
      exp_req_pc = RESET_PC;
      perf_m     = 32'd0;
    end else begin
      if (ibq.size() == 0 && perf_m != 32'hFFFF_FFFF) perf_m++;
      a = 32'd0;
      if (go) a = memq.pop_front();
      if (k_redir) begin
        ibq.delete();
        drop_m     = memq.size();
        exp_req_pc = {k_target[31:2], 2'b00};
      end else begin
        if (ibq.size() > 0 && !k_stall) void'(ibq.pop_front());
        if (go) begin
          if (drop_m > 0) drop_m--;
          else begin
            e.pc = a;
            e.instr = memdata(a);
            ibq.push_back(e);
          end
        end
      end
      if (s_req_valid && k_ready) begin
        memq.push_back(s_req_addr);
        if (!k_redir) exp_req_pc += 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    k_reset = 1; k_ready = 1; k_rsp_mode = 1; k_stall = 0; k_redir = 0;
    repeat (3) tick();
    n_cmp++; if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%0b exp=0", s_req_valid); end
    n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", s_valid); end
    n_cmp++; if (s_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", s_instr); end
    n_cmp++; if (s_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", s_pc); end
    n_cmp++; if (s_perf !== 32'd0) begin n_fail++; $display("FAIL reset_perf got=%0d exp=0", s_perf); end
    $display("test_reset: done at cycle %0d", cyc);
  endtask

  task automatic test_basic();
    int first_req, first_val, nreq, npop;
    logic [31:0] ep;
    k_reset = 1; tick();
    k_reset = 0; k_ready = 1; k_rsp_mode = 1; k_stall = 0; k_redir = 0;
    first_req = -1; first_val = -1; nreq = 0; npop = 0;
    for (int i = 0; i < 20 && npop < 3; i++) begin
      tick();
      if (s_req_valid && k_ready) begin
        if (first_req < 0) first_req = i;
        if (nreq < 3) begin
          ep = RESET_PC + 32'(4 * nreq);
          n_cmp++; if (s_req_addr !== ep) begin n_fail++; $display("FAIL basic_req_addr got=%h exp=%h", s_req_addr, ep); end
        end
        nreq++;
      end
      if (s_valid) begin
        if (first_val < 0) first_val = i;
        ep = RESET_PC + 32'(4 * npop);
        n_cmp++; if (s_pc !== ep) begin n_fail++; $display("FAIL basic_pc got=%h exp=%h", s_pc, ep); end
        n_cmp++; if (s_instr !== memdata(ep)) begin n_fail++; $display("FAIL basic_instr got=%h exp=%h", s_instr, memdata(ep)); end
        npop++;
      end
    end
    n_cmp++; if (npop != 3) begin n_fail++; $display("FAIL basic_timeout got=%0d pops exp=3", npop); end
    n_cmp++; if (first_val - first_req != 2) begin n_fail++; $display("FAIL basic_latency got=%0d exp=2", first_val - first_req); end
    $display("test_basic: first_req=%0d first_valid=%0d", first_req, first_val);
  endtask

  task automatic test_stall();
    logic [31:0] held_pc, held_instr, ep;
    int npop;
    k_reset = 0; k_ready = 1; k_rsp_mode = 1; k_stall = 0; k_redir = 0;
    repeat (4) tick();
    k_stall = 1;
    held_pc = 32'd0; held_instr = 32'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        held_pc = s_pc; held_instr = s_instr;
        n_cmp++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got=%0b exp=1", s_valid); end
      end
      n_cmp++; if (s_pc !== held_pc) begin n_fail++; $display("FAIL stall_pc_hold got=%h exp=%h", s_pc, held_pc); end
      n_cmp++; if (s_instr !== held_instr) begin n_fail++; $display("FAIL stall_instr_hold got=%h exp=%h", s_instr, held_instr); end
      n_cmp++; if (s_req_valid !== e_req_valid) begin n_fail++; $display("FAIL stall_credit got=%0b exp=%0b", s_req_valid, e_req_valid); end
    end
    n_cmp++; if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_full_issue got=%0b exp=0", s_req_valid); end
    k_stall = 0;
    ep = held_pc; npop = 0;
    for (int i = 0; i < 40 && npop < 8; i++) begin
      tick();
      if (s_valid) begin
        n_cmp++; if (s_pc !== ep) begin n_fail++; $display("FAIL stall_resume_pc got=%h exp=%h", s_pc, ep); end
        n_cmp++; if (s_instr !== memdata(ep)) begin n_fail++; $display("FAIL stall_resume_instr got=%h exp=%h", s_instr, memdata(ep)); end
        ep += 32'd4; npop++;
      end
    end
    n_cmp++; if (npop != 8) begin n_fail++; $display("FAIL stall_resume_timeout got=%0d exp=8", npop); end
    $display("test_stall: held pc=%h, resumed %0d instructions", held_pc, npop);
  endtask

  task automatic test_redirect_outstanding();
    int nval;
    logic [31:0] ep;
    k_reset = 1; tick();
    k_reset = 0; k_ready = 1; k_rsp_mode = 0; k_rsp_force = 0; k_stall = 0; k_redir = 0;
    for (int i = 0; i < 10 && memq.size() < 3; i++) tick();
    n_cmp++; if (memq.size() != 3) begin n_fail++; $display("FAIL redir3_setup got=%0d outstanding exp=3", memq.size()); end
    k_redir = 1; k_target = 32'h0000_1003;
    tick();
    n_cmp++; if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir3_no_issue got=%0b exp=0", s_req_valid); end
    k_redir = 0; k_rsp_mode = 1;
    tick();
    n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL redir3_valid_after got=%0b exp=0", s_valid); end
    n_cmp++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_1000) begin
      n_fail++; $display("FAIL redir3_first_req got=%0b/%h exp=1/00001000", s_req_valid, s_req_addr);
    end
    nval = 0; ep = 32'h0000_1000;
    for (int i = 0; i < 30 && nval < 2; i++) begin
      tick();
      if (s_valid) begin
        n_cmp++; if (s_pc !== ep) begin n_fail++; $display("FAIL redir3_pc got=%h exp=%h", s_pc, ep); end
        n_cmp++; if (s_instr !== memdata(ep)) begin n_fail++; $display("FAIL redir3_instr got=%h exp=%h", s_instr, memdata(ep)); end
        ep += 32'd4; nval++;
      end
    end
    n_cmp++; if (nval != 2) begin n_fail++; $display("FAIL redir3_timeout got=%0d exp=2", nval); end
    $display("test_redirect_outstanding: %0d instructions after redirect", nval);
  endtask

  task automatic test_redirect_with_rsp();
    bit found;
    k_reset = 1; tick();
    k_reset = 0; k_ready = 1; k_rsp_mode = 0; k_rsp_force = 0; k_stall = 0; k_redir = 0;
    for (int i = 0; i < 5 && memq.size() < 1; i++) tick();
    k_redir = 1; k_rsp_force = 1; k_target = 32'h0000_2468;
    tick();
    k_redir = 0; k_rsp_force = 0; k_rsp_mode = 1;
    tick();
    n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL redir_rsp_valid_after got=%0b exp=0", s_valid); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_valid) begin
        found = 1;
        n_cmp++; if (s_pc !== 32'h0000_2468) begin n_fail++; $display("FAIL redir_rsp_pc got=%h exp=00002468", s_pc); end
        n_cmp++; if (s_instr !== memdata(32'h0000_2468)) begin n_fail++; $display("FAIL redir_rsp_instr got=%h exp=%h", s_instr, memdata(32'h0000_2468)); end
      end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL redir_rsp_timeout got=none exp=valid"); end
    $display("test_redirect_with_rsp: done at cycle %0d", cyc);
  endtask

  task automatic test_ready_low();
    logic [31:0] held;
    k_reset = 1; tick();
    k_reset = 0; k_ready = 1; k_rsp_mode = 1; k_stall = 0; k_redir = 0;
    repeat (4) tick();
    k_ready = 0;
    held = 32'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) held = s_req_addr;
      n_cmp++; if (s_req_valid !== 1'b1 || s_req_addr !== held) begin
        n_fail++; $display("FAIL ready_low_hold got=%0b/%h exp=1/%h", s_req_valid, s_req_addr, held);
      end
    end
    n_cmp++; if (held !== RESET_PC + 32'd16) begin n_fail++; $display("FAIL ready_low_addr got=%h exp=%h", held, RESET_PC + 32'd16); end
    k_ready = 1;
    tick();
    n_cmp++; if (s_req_addr !== held) begin n_fail++; $display("FAIL ready_high_addr got=%h exp=%h", s_req_addr, held); end
    tick();
    n_cmp++; if (s_req_addr !== held + 32'd4) begin n_fail++; $display("FAIL ready_high_next got=%h exp=%h", s_req_addr, held + 32'd4); end
    $display("test_ready_low: held address %h", held);
  endtask

  task automatic test_perf();
    logic [31:0] ep;
    k_reset = 1; tick();
    k_reset = 0; k_ready = 0; k_rsp_mode = 1; k_stall = 0; k_redir = 0;
    repeat (6) tick();
    tick();
`ifdef FETCH_PERF_CNT_EN
    ep = 32'd6;
`else
    ep = 32'd0;
`endif
    n_cmp++; if (s_perf !== ep) begin n_fail++; $display("FAIL perf_empty_cnt got=%0d exp=%0d", s_perf, ep); end
    n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL perf_valid got=%0b exp=0", s_valid); end
    $display("test_perf: perf_ibuf_empty_cnt=%0d", s_perf);
  endtask

  task automatic test_random();
    int start_fail;
    start_fail = n_fail;
    k_reset = 1; tick();
    k_rsp_mode = 2; k_rsp_force = 0;
    for (int i = 0; i < 1500; i++) begin
      k_reset  = ($urandom_range(199, 0) == 0);
      k_ready  = ($urandom_range(3, 0) != 0);
      k_stall  = ($urandom_range(2, 0) == 0);
      k_redir  = ($urandom_range(29, 0) == 0);
      k_target = $urandom();
      tick();
      n_cmp++; if (s_req_valid !== e_req_valid) begin n_fail++; $display("FAIL rnd_req_valid cyc=%0d got=%0b exp=%0b", cyc, s_req_valid, e_req_valid); end
      if (e_req_valid) begin
        n_cmp++; if (s_req_addr !== e_req_addr) begin n_fail++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, s_req_addr, e_req_addr); end
      end
      n_cmp++; if (s_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, s_valid, e_valid); end
      if (e_valid && !k_redir) begin
        n_cmp++; if (s_pc !== e_pc || s_instr !== e_instr) begin
          n_fail++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", cyc, s_pc, s_instr, e_pc, e_instr);
        end
      end
      n_cmp++; if (s_perf !== e_perf) begin n_fail++; $display("FAIL rnd_perf cyc=%0d got=%0d exp=%0d", cyc, s_perf, e_perf); end
    end
    k_reset = 0; k_redir = 0; k_stall = 0;
    $display("test_random: 1500 cycles, %0d new mismatches", n_fail - start_fail);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_outstanding();
    test_redirect_with_rsp();
    test_ready_low();
    test_perf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
